// File: rtl/branch_stack_if.sv
// rtl/branch_stack_if.sv - branch checkpoint stack bus; BS_PERF_EN adds perf counter outputs
interface branch_stack_if #(
    parameter int BS_DEPTH = 4,
    parameter int LREG_W   = 5,
    parameter int PREG_W   = 6
);
    localparam int TAG_W   = (BS_DEPTH > 1) ? $clog2(BS_DEPTH) : 1;
    localparam int STATE_W = (2 ** LREG_W) * (PREG_W + 1);

    logic                   push_valid;
    logic [STATE_W-1:0]     push_state;
    logic [PREG_W-1:0]      push_fl_head;
    logic [TAG_W-1:0]       push_tag;
    logic                   full;
    logic                   resolve_valid;
    logic [TAG_W-1:0]       resolve_tag;
    logic                   resolve_mispredict;
    logic [2:0]             cdb_valid;
    logic [3*LREG_W-1:0]    cdb_lreg;
    logic [3*PREG_W-1:0]    cdb_preg;
    logic                   branch_recover;
    logic [STATE_W-1:0]     recover_state;
    logic [PREG_W-1:0]      recover_fl_head;
    logic [BS_DEPTH-1:0]    squash_mask;
    logic [TAG_W:0]         count;
`ifdef BS_PERF_EN
    logic [31:0]            resolve_count;
    logic [31:0]            mispredict_count;

    modport master (
        output push_valid, push_state, push_fl_head, resolve_valid, resolve_tag,
               resolve_mispredict, cdb_valid, cdb_lreg, cdb_preg,
        input  push_tag, full, branch_recover, recover_state, recover_fl_head,
               squash_mask, count, resolve_count, mispredict_count
    );
    modport slave (
        input  push_valid, push_state, push_fl_head, resolve_valid, resolve_tag,
               resolve_mispredict, cdb_valid, cdb_lreg, cdb_preg,
        output push_tag, full, branch_recover, recover_state, recover_fl_head,
               squash_mask, count, resolve_count, mispredict_count
    );
`else
    modport master (
        output push_valid, push_state, push_fl_head, resolve_valid, resolve_tag,
               resolve_mispredict, cdb_valid, cdb_lreg, cdb_preg,
        input  push_tag, full, branch_recover, recover_state, recover_fl_head,
               squash_mask, count
    );
    modport slave (
        input  push_valid, push_state, push_fl_head, resolve_valid, resolve_tag,
               resolve_mispredict, cdb_valid, cdb_lreg, cdb_preg,
        output push_tag, full, branch_recover, recover_state, recover_fl_head,
               squash_mask, count
    );
`endif
endinterface

// File: rtl/branch_stack.sv
// rtl/branch_stack.sv - rename checkpoint stack with nested squash; BS_PERF_EN adds resolve/mispredict counters
module branch_stack #(
    parameter int BS_DEPTH = 4,
    parameter int LREG_W   = 5,
    parameter int PREG_W   = 6
) (
    input  logic               clock,
    input  logic               reset,
    branch_stack_if.slave      bus
);
    localparam int TAG_W   = (BS_DEPTH > 1) ? $clog2(BS_DEPTH) : 1;
    localparam int ENT_W   = PREG_W + 1;
    localparam int STATE_W = (2 ** LREG_W) * ENT_W;

    logic [BS_DEPTH-1:0] valid_q, valid_d;
    logic [STATE_W-1:0]  state_q  [BS_DEPTH];
    logic [STATE_W-1:0]  state_d  [BS_DEPTH];
    logic [PREG_W-1:0]   fl_q     [BS_DEPTH];
    logic [PREG_W-1:0]   fl_d     [BS_DEPTH];
    logic [BS_DEPTH-1:0] ymask_q  [BS_DEPTH];
    logic [BS_DEPTH-1:0] ymask_d  [BS_DEPTH];

    logic                recover_q, recover_d;
    logic [STATE_W-1:0]  rstate_q, rstate_d;
    logic [PREG_W-1:0]   rfl_q, rfl_d;
    logic [BS_DEPTH-1:0] squash_q, squash_d;

    logic [TAG_W-1:0]    free_tag;
    logic                free_found;
    logic [TAG_W:0]      cnt;
    logic [BS_DEPTH-1:0] rt_oh, kill;
    logic                full_w, res_hit, mis_hit, ok_hit, mis_req, push_ok;

    // Marks an lreg ready when a CDB lane broadcasts the preg it is renamed to.
    function automatic logic [STATE_W-1:0] cdb_apply(
        input logic [STATE_W-1:0]  s,
        input logic [2:0]          cv,
        input logic [3*LREG_W-1:0] cl,
        input logic [3*PREG_W-1:0] cp
    );
        logic [STATE_W-1:0] r;
        int                 base;
        r = s;
        for (int k = 0; k < 3; k++) begin
            base = int'(cl[k*LREG_W +: LREG_W]) * ENT_W;
            if (cv[k] && (s[base +: PREG_W] == cp[k*PREG_W +: PREG_W]))
                r[base + PREG_W] = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        free_tag   = '0;
        free_found = 1'b0;
        cnt        = '0;
        for (int i = 0; i < BS_DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_tag   = TAG_W'(i);
                free_found = 1'b1;
            end
            cnt = cnt + (TAG_W+1)'(valid_q[i]);
            rt_oh[i] = (bus.resolve_tag == TAG_W'(i));
        end
    end

    assign full_w  = &valid_q;
    assign res_hit = bus.resolve_valid & |(valid_q & rt_oh);
    assign mis_req = bus.resolve_valid & bus.resolve_mispredict;
    assign mis_hit = res_hit & bus.resolve_mispredict;
    assign ok_hit  = res_hit & ~bus.resolve_mispredict;
    assign push_ok = bus.push_valid & ~full_w & ~mis_req;
    assign kill    = mis_hit ? (ymask_q[bus.resolve_tag] | rt_oh) :
                     ok_hit  ? rt_oh : '0;

    always_comb begin
        valid_d = valid_q & ~kill;
        for (int i = 0; i < BS_DEPTH; i++) begin
            state_d[i] = cdb_apply(state_q[i], bus.cdb_valid, bus.cdb_lreg, bus.cdb_preg);
            fl_d[i]    = fl_q[i];
            ymask_d[i] = ymask_q[i] & ~kill;
        end
        // The new branch is younger than every entry surviving this cycle.
        if (push_ok) begin
            for (int j = 0; j < BS_DEPTH; j++)
                if (valid_d[j]) ymask_d[j][free_tag] = 1'b1;
            valid_d[free_tag] = 1'b1;
            state_d[free_tag] = cdb_apply(bus.push_state, bus.cdb_valid, bus.cdb_lreg, bus.cdb_preg);
            fl_d[free_tag]    = bus.push_fl_head;
            ymask_d[free_tag] = '0;
        end
    end

    always_comb begin
        recover_d = mis_hit;
        rstate_d  = '0;
        rfl_d     = '0;
        squash_d  = '0;
        if (mis_hit) begin
            rstate_d = cdb_apply(state_q[bus.resolve_tag], bus.cdb_valid, bus.cdb_lreg, bus.cdb_preg);
            rfl_d    = fl_q[bus.resolve_tag];
            squash_d = kill;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            recover_q <= 1'b0;
            rstate_q  <= '0;
            rfl_q     <= '0;
            squash_q  <= '0;
            for (int i = 0; i < BS_DEPTH; i++) begin
                state_q[i] <= '0;
                fl_q[i]    <= '0;
                ymask_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            recover_q <= recover_d;
            rstate_q  <= rstate_d;
            rfl_q     <= rfl_d;
            squash_q  <= squash_d;
            for (int i = 0; i < BS_DEPTH; i++) begin
                state_q[i] <= state_d[i];
                fl_q[i]    <= fl_d[i];
                ymask_q[i] <= ymask_d[i];
            end
        end
    end

`ifdef BS_PERF_EN
    logic [31:0] res_cnt_q, mis_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (res_hit && (res_cnt_q != '1)) res_cnt_q <= res_cnt_q + 32'd1;
            if (mis_hit && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign bus.resolve_count    = res_cnt_q;
    assign bus.mispredict_count = mis_cnt_q;
`endif

    assign bus.push_tag        = free_tag;
    assign bus.full            = full_w;
    assign bus.count           = cnt;
    assign bus.branch_recover  = recover_q;
    assign bus.recover_state   = rstate_q;
    assign bus.recover_fl_head = rfl_q;
    assign bus.squash_mask     = squash_q;
endmodule

// File: tb/tb_branch_stack.sv
// tb/tb_branch_stack.sv - scoreboard bench for branch_stack; define BS_PERF_EN to cover perf counters
module tb_branch_stack;
    localparam int D  = 4;
    localparam int L  = 5;
    localparam int P  = 6;
    localparam int EW = P + 1;
    localparam int SW = 32 * EW;

    typedef struct {
        logic [D-1:0]  squash;
        logic [SW-1:0] st;
        logic [P-1:0]  fl;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    rec_t exp_q[$];

    branch_stack_if #(.BS_DEPTH(D), .LREG_W(L), .PREG_W(P)) bs ();

    branch_stack #(.BS_DEPTH(D), .LREG_W(L), .PREG_W(P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bs.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] mk(input int lr, input logic [P-1:0] pr, input logic v);
        logic [SW-1:0] s;
        s = '0;
        s[lr*EW +: P]  = pr;
        s[lr*EW + P]   = v;
        return s;
    endfunction

    always @(negedge clock) begin
        rec_t e;
        if (bs.branch_recover === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_recover: got squash %0h expected no recovery", bs.squash_mask);
            end else begin
                e = exp_q.pop_front();
                chk("squash_mask", SW'(bs.squash_mask), SW'(e.squash));
                chk("recover_state", bs.recover_state, e.st);
                chk("recover_fl_head", SW'(bs.recover_fl_head), SW'(e.fl));
            end
        end else begin
            chk("recover_idle_zero", SW'({bs.squash_mask, bs.recover_fl_head, |bs.recover_state}), '0);
        end
    end

    task automatic idle_inputs();
        bs.push_valid         = 1'b0;
        bs.push_state         = '0;
        bs.push_fl_head       = '0;
        bs.resolve_valid      = 1'b0;
        bs.resolve_tag        = '0;
        bs.resolve_mispredict = 1'b0;
        bs.cdb_valid          = '0;
        bs.cdb_lreg           = '0;
        bs.cdb_preg           = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [SW-1:0] st, input logic [P-1:0] fl, input int exp_tag);
        bs.push_valid   = 1'b1;
        bs.push_state   = st;
        bs.push_fl_head = fl;
        #1;
        if (exp_tag >= 0) chk("push_tag", SW'(bs.push_tag), SW'(exp_tag));
        tick();
        bs.push_valid = 1'b0;
    endtask

    task automatic resolve(input int tag, input logic mis);
        bs.resolve_valid      = 1'b1;
        bs.resolve_tag        = 2'(tag);
        bs.resolve_mispredict = mis;
        tick();
        bs.resolve_valid      = 1'b0;
        bs.resolve_mispredict = 1'b0;
    endtask

    task automatic mispredict(input int tag, input logic [D-1:0] sq, input logic [SW-1:0] st, input logic [P-1:0] fl);
        rec_t e;
        e.squash = sq;
        e.st     = st;
        e.fl     = fl;
        exp_q.push_back(e);
        resolve(tag, 1'b1);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        idle_inputs();
        repeat (2) tick();
        chk("reset_count", SW'(bs.count), '0);
        chk("reset_full", SW'(bs.full), '0);
        chk("reset_push_tag", SW'(bs.push_tag), '0);
        chk("reset_recover", SW'(bs.branch_recover), '0);
        reset = 1'b1;
        tick();

        // Fill, then overflow push is dropped
        for (int i = 0; i < 4; i++) push(mk(i, P'(10 + i), 1'b1), P'(20 + i), i);
        chk("fill_count", SW'(bs.count), SW'(4));
        chk("fill_full", SW'(bs.full), SW'(1));
        push(mk(9, 6'd9, 1'b1), 6'd63, -1);
        chk("overflow_count", SW'(bs.count), SW'(4));

        // Nested squash from tag 1, entry 0 survives
        mispredict(1, 4'b1110, mk(1, 6'd11, 1'b1), 6'd21);
        chk("squash1_count", SW'(bs.count), SW'(1));
        chk("squash1_full", SW'(bs.full), '0);
        mispredict(0, 4'b0001, mk(0, 6'd10, 1'b1), 6'd20);
        chk("squash0_count", SW'(bs.count), '0);

        // Correct resolve with same-cycle push; freed tag not reused
        for (int i = 0; i < 3; i++) push(mk(i, P'(30 + i), 1'b1), P'(40 + i), i);
        bs.resolve_valid      = 1'b1;
        bs.resolve_tag        = 2'd1;
        bs.resolve_mispredict = 1'b0;
        push(mk(3, 6'd33, 1'b1), 6'd43, 3);
        bs.resolve_valid = 1'b0;
        chk("resolve_push_count", SW'(bs.count), SW'(3));
        mispredict(0, 4'b1101, mk(0, 6'd30, 1'b1), 6'd40);
        chk("after_1101_count", SW'(bs.count), '0);

        // CDB wakeup in a stored entry and on the recovery cycle itself
        push(mk(5, 6'd40, 1'b0) | mk(7, 6'd33, 1'b0), 6'd50, 0);
        bs.cdb_valid = 3'b111;
        bs.cdb_lreg  = {5'd5, 5'd6, 5'd5};
        bs.cdb_preg  = {6'd40, 6'd40, 6'd41};
        tick();
        bs.cdb_valid = 3'b001;
        bs.cdb_lreg  = {5'd0, 5'd0, 5'd7};
        bs.cdb_preg  = {6'd0, 6'd0, 6'd33};
        mispredict(0, 4'b0001, mk(5, 6'd40, 1'b1) | mk(7, 6'd33, 1'b1), 6'd50);
        idle_inputs();

        // Push dropped under mispredict; invalid-tag resolves ignored
        for (int i = 0; i < 3; i++) push(mk(i, P'(i + 1), 1'b1), P'(i), i);
        bs.push_valid = 1'b1;
        bs.push_state = mk(9, 6'd9, 1'b1);
        mispredict(2, 4'b0100, mk(2, 6'd3, 1'b1), 6'd2);
        bs.push_valid = 1'b0;
        chk("drop_push_count", SW'(bs.count), SW'(2));
        resolve(3, 1'b1);
        chk("invalid_mis_count", SW'(bs.count), SW'(2));
        resolve(3, 1'b0);
        chk("invalid_ok_count", SW'(bs.count), SW'(2));
        tick();
        push(mk(4, 6'd4, 1'b1), 6'd4, 2);
        chk("reuse_count", SW'(bs.count), SW'(3));

        // Reset lands in the recovery cycle
        bs.resolve_valid      = 1'b1;
        bs.resolve_tag        = 2'd0;
        bs.resolve_mispredict = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("rst_mid_recover", SW'(bs.branch_recover), '0);
        chk("rst_mid_squash", SW'(bs.squash_mask), '0);
        chk("rst_mid_state", bs.recover_state, '0);
        chk("rst_mid_count", SW'(bs.count), '0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_recover", SW'(bs.branch_recover), '0);

        // Three valid resolves, one of them a mispredict
        for (int i = 0; i < 3; i++) push(mk(i, P'(i + 8), 1'b1), P'(i + 8), i);
        resolve(0, 1'b0);
        resolve(1, 1'b0);
        mispredict(2, 4'b0100, mk(2, 6'd10, 1'b1), 6'd10);
        chk("perf_seq_count", SW'(bs.count), '0);
`ifdef BS_PERF_EN
        chk("resolve_count", SW'(bs.resolve_count), SW'(3));
        chk("mispredict_count", SW'(bs.mispredict_count), SW'(1));
`endif
        repeat (2) tick();
        chk("scoreboard_drained", SW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_stack.md
BRANCH_STACK -- requirements
Module: branch_stack

Interface
REQ-001 SHALL have parameter BS_DEPTH, default 4, number of checkpoint entries.
REQ-002 SHALL have parameter LREG_W, default 5, logical register index width (32 logical regs).
REQ-003 SHALL have parameter PREG_W, default 6, physical register tag width (64 physical regs).
REQ-004 SHALL have port clock  in  1  sole clock; all state changes on posedge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port push_valid  in  1  dispatched branch requests a checkpoint.
REQ-007 SHALL have port push_state  in  32*(PREG_W+1)  map table snapshot, per lreg {valid, renamed_preg}.
REQ-008 SHALL have port push_fl_head  in  PREG_W  free-list head pointer to checkpoint.
REQ-009 SHALL have port push_tag  out  log2(BS_DEPTH)  tag granted to this cycle's push; combinational.
REQ-010 SHALL have port full  out  1  all entries valid.
REQ-011 SHALL have port resolve_valid / resolve_tag / resolve_mispredict  in  1 / log2(BS_DEPTH) / 1  branch resolution.
REQ-012 SHALL have port cdb_valid / cdb_lreg / cdb_preg  in  3 / 3*LREG_W / 3*PREG_W  three completion lanes.
REQ-013 SHALL have port branch_recover  out  1  registered recovery strobe to map table and free list.
REQ-014 SHALL have port recover_state / recover_fl_head  out  32*(PREG_W+1) / PREG_W  registered restored values.
REQ-015 SHALL have port squash_mask  out  BS_DEPTH  registered set of tags killed this recovery.
REQ-016 SHALL have port count  out  log2(BS_DEPTH)+1  number of valid entries.

Function
REQ-017 SHALL store per entry: valid, state snapshot, fl_head, younger_mask[BS_DEPTH].
REQ-018 SHALL grant push_tag = lowest-index invalid entry; push accepted iff push_valid & !full & !(resolve_valid & resolve_mispredict).
REQ-019 On accepted push, SHALL write the entry next edge and set its bit in younger_mask of every entry valid that cycle; new entry's own younger_mask SHALL be zero.
REQ-020 Push while full SHALL be dropped, no state change; push coincident with a mispredict SHALL be dropped.
REQ-021 Correct resolve (resolve_valid & !resolve_mispredict) on a valid tag T SHALL clear entry T and bit T in all younger_masks next edge.
REQ-022 Mispredict on valid tag T SHALL invalidate T and all entries in younger_mask[T]; squash_mask SHALL equal that set plus T.
REQ-023 Mispredict SHALL drive branch_recover=1 for exactly one cycle after the resolve edge, with recover_state/recover_fl_head from entry T including same-cycle CDB updates.
REQ-024 Resolve on an invalid tag SHALL be ignored; branch_recover SHALL stay 0.
REQ-025 Each cycle, for every valid entry and every lane k with cdb_valid[k], if entry.lreg[cdb_lreg[k]].renamed_preg == cdb_preg[k], SHALL set that lreg's valid bit; also applied to push_state being written.
REQ-026 Correct resolve and push in same cycle SHALL both take effect; a freed tag SHALL not be reused by that same-cycle push.
REQ-027 count and full SHALL reflect registered valid bits (updated one edge after push/resolve).
REQ-028 When branch_recover=0, recover_state, recover_fl_head and squash_mask SHALL be zero.

Reset
REQ-029 While reset=0, SHALL clear all valid bits and younger_masks, and drive branch_recover=0, squash_mask=0, recover_state=0, recover_fl_head=0, count=0, full=0, push_tag=0.
REQ-030 Reset asserted mid-recovery SHALL abort recovery immediately; first post-reset cycle SHALL show branch_recover=0.

Configuration
REQ-031 With BS_PERF_EN defined, SHALL add outputs resolve_count and mispredict_count (32 bits each, reset 0, saturating, +1 per valid-tag resolve / mispredict); without it those ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-032 Reset, then 4 pushes on consecutive cycles -> tags 0,1,2,3; full=1, count=4; 5th push dropped, count stays 4.
REQ-033 Entries 0..3 valid; mispredict tag 1 -> next cycle branch_recover=1, squash_mask=4'b1110, count=1, entry 0 intact.
REQ-034 Entries 0..2 valid; correct resolve tag 1 plus push same cycle -> new tag 3, count=3; later mispredict tag 0 squashes 4'b1101.
REQ-035 Checkpoint with lreg 5 -> preg 40 invalid; cdb lane 2 {lreg 5, preg 40}; mispredict -> recover_state lreg 5 valid=1, preg 40.
REQ-036 Mispredict tag 2 with push_valid=1 same cycle -> push dropped; resolve of invalid tag 3 -> no recover, no state change.
REQ-037 Assert reset during branch_recover cycle -> outputs zero asynchronously; BS_PERF_EN build: 3 resolves, 1 mispredict -> resolve_count=3, mispredict_count=1.
